// File: rtl/attribute_reconstructor.sv
// Attribute reconstructor: adds a signed residual to an external prediction,
// saturates to the attribute range, streams the result out with a one-beat
// output register and keeps a K-deep history of reconstructed values for the
// predictor.
module attribute_reconstructor #(
  parameter int unsigned ATTR_WIDTH = 8,
  parameter int unsigned K          = 4,
  parameter int unsigned MODE_WIDTH = 3,
  parameter int unsigned RES_WIDTH  = 9,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_frame,
  input  logic [CNT_WIDTH-1:0]    frame_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MODE_WIDTH-1:0]   in_mode,
  input  logic [RES_WIDTH-1:0]    in_residual,
  output logic [K*ATTR_WIDTH-1:0] pred_neighbors,
  output logic [MODE_WIDTH-1:0]   pred_mode,
  input  logic [ATTR_WIDTH-1:0]   pred_attr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ATTR_WIDTH-1:0]   out_attr,
  output logic [CNT_WIDTH-1:0]    out_index,
  output logic                    frame_done
);

  // Two extra bits: one for the sign, one so the sum of the two operands never overflows.
  localparam int unsigned MaxW  = (ATTR_WIDTH > RES_WIDTH) ? ATTR_WIDTH : RES_WIDTH;
  localparam int unsigned CalcW = MaxW + 2;

  localparam logic StIdle   = 1'b0;
  localparam logic StActive = 1'b1;

  localparam logic signed [CalcW-1:0] AttrMax =
    {{(CalcW - ATTR_WIDTH){1'b0}}, {ATTR_WIDTH{1'b1}}};

  logic                    state_q, state_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [K*ATTR_WIDTH-1:0] hist_q, hist_d;
  logic                    out_valid_q, out_valid_d;
  logic [ATTR_WIDTH-1:0]   out_attr_q, out_attr_d;
  logic [CNT_WIDTH-1:0]    out_index_q, out_index_d;
  // Marks that the registered output is the last point of its frame.
  logic                    out_last_q, out_last_d;
  // Completion pulse for a zero-length frame, which never produces an output.
  logic                    zero_done_q, zero_done_d;

  logic                    accept;
  logic                    out_hs;
  logic                    start_ok;
  logic signed [CalcW-1:0] pred_ext;
  logic signed [CalcW-1:0] res_ext;
  logic signed [CalcW-1:0] sum;
  logic [ATTR_WIDTH-1:0]   recon;

  assign in_ready = (state_q == StActive) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;
  // A new frame waits until the previous frame's last output has left.
  assign start_ok = start_frame & (state_q == StIdle) & ~out_valid_q;

  assign pred_mode      = in_mode;
  assign pred_neighbors = hist_q;

  assign out_valid  = out_valid_q;
  assign out_attr   = out_attr_q;
  assign out_index  = out_index_q;
  assign frame_done = zero_done_q | (out_hs & out_last_q);

  // Prediction is unsigned (zero-extended), residual is two's complement (sign-extended).
  assign pred_ext = $signed({{(CalcW - ATTR_WIDTH){1'b0}}, pred_attr});
  assign res_ext  = $signed({{(CalcW - RES_WIDTH){in_residual[RES_WIDTH-1]}}, in_residual});
  assign sum      = pred_ext + res_ext;

  // Saturate the reconstructed value into [0, 2^ATTR_WIDTH - 1].
  always_comb begin
    if (sum[CalcW-1]) begin
      recon = '0;
    end else if (sum > AttrMax) begin
      recon = '1;
    end else begin
      recon = sum[ATTR_WIDTH-1:0];
    end
  end

  // Next-state: frame control, accept path, history shift and output handshake.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    hist_d      = hist_q;
    out_valid_d = out_valid_q;
    out_attr_d  = out_attr_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    zero_done_d = 1'b0;

    // Handshake drains the output register; a same-cycle accept refills it below.
    if (out_hs) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (state_q == StIdle) begin
      if (start_ok) begin
        if (frame_len != '0) begin
          state_d     = StActive;
          remaining_d = frame_len;
          cnt_d       = '0;
          hist_d      = '0;
        end else begin
          zero_done_d = 1'b1;
        end
      end
    end else if (accept) begin
      for (int i = K - 1; i > 0; i--) begin
        hist_d[i*ATTR_WIDTH +: ATTR_WIDTH] = hist_q[(i-1)*ATTR_WIDTH +: ATTR_WIDTH];
      end
      hist_d[0 +: ATTR_WIDTH] = recon;
      out_valid_d = 1'b1;
      out_attr_d  = recon;
      out_index_d = cnt_q;
      cnt_d       = cnt_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
      out_last_d  = (remaining_q == CNT_WIDTH'(1));
      if (remaining_q == CNT_WIDTH'(1)) begin
        state_d = StIdle;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt_q       <= '0;
      hist_q      <= '0;
      out_valid_q <= 1'b0;
      out_attr_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      hist_q      <= hist_d;
      out_valid_q <= out_valid_d;
      out_attr_q  <= out_attr_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      zero_done_q <= zero_done_d;
    end
  end

endmodule
